// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle multiply/divide unit owning the HI/LO register pair
module muldiv_unit #(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 2,
    parameter int DIV_BITS    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int N  = WIDTH / DIV_BITS;
    localparam int CW = $clog2(WIDTH + 1) + 1;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  opa_q, opa_d;
    logic [WIDTH-1:0]  opb_q, opb_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic              sgn_q, sgn_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;
    logic              divz_q, divz_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic              done_q, done_d;
    logic              dbz_q, dbz_d;

    logic              accept;
    logic              a_neg, b_neg;
    logic [2*WIDTH-1:0] ext_a, ext_b, prod;
    logic [WIDTH:0]    it_rem;
    logic [WIDTH-1:0]  it_quo;

    assign accept = start && (state_q == S_IDLE);
    assign a_neg  = (op == OP_DIV) && a[WIDTH-1];
    assign b_neg  = (op == OP_DIV) && b[WIDTH-1];

    // Operands are sign- or zero-extended to full product width so one multiplier serves both ops.
    assign ext_a = {{WIDTH{sgn_q & opa_q[WIDTH-1]}}, opa_q};
    assign ext_b = {{WIDTH{sgn_q & opb_q[WIDTH-1]}}, opb_q};
    assign prod  = ext_a * ext_b;

    // Restoring divide step: dividend bits shift out of opa while quotient bits shift in.
    always_comb begin
        it_rem = {1'b0, rem_q};
        it_quo = opa_q;
        for (int i = 0; i < DIV_BITS; i++) begin
            it_rem = {it_rem[WIDTH-1:0], it_quo[WIDTH-1]};
            it_quo = {it_quo[WIDTH-2:0], 1'b0};
            if (it_rem >= {1'b0, opb_q}) begin
                it_rem    = it_rem - {1'b0, opb_q};
                it_quo[0] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            rem_q   <= '0;
            sgn_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            divz_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            rem_q   <= rem_d;
            sgn_q   <= sgn_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            divz_q  <= divz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (op == OP_MULT || op == OP_MULTU) begin
                        state_d = S_MUL;
                    end else if (op == OP_DIV || op == OP_DIVU) begin
                        state_d = (b == '0) ? S_FIX : S_DIV;
                    end
                end
            end
            S_MUL:   if (cnt_q == '0) state_d = S_IDLE;
            S_DIV:   if (cnt_q == '0) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        opa_d  = opa_q;
        opb_d  = opb_q;
        rem_d  = rem_q;
        sgn_d  = sgn_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        divz_d = divz_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        done_d = 1'b0;
        dbz_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            opa_d = a;
                            opb_d = b;
                            sgn_d = (op == OP_MULT);
                            cnt_d = CW'(MUL_LATENCY - 1);
                        end
                        OP_DIV, OP_DIVU: begin
                            // On divide-by-zero opa keeps the raw dividend so FIX can copy it to HI.
                            divz_d = (b == '0);
                            opa_d  = (b == '0) ? a : (a_neg ? -a : a);
                            opb_d  = b_neg ? -b : b;
                            rem_d  = '0;
                            qneg_d = a_neg ^ b_neg;
                            rneg_d = a_neg;
                            cnt_d  = CW'(N - 1);
                        end
                        OP_MTHI: begin
                            hi_d   = a;
                            done_d = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_d   = a;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                if (cnt_q == '0) begin
                    hi_d   = prod[2*WIDTH-1:WIDTH];
                    lo_d   = prod[WIDTH-1:0];
                    done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DIV: begin
                opa_d = it_quo;
                rem_d = it_rem[WIDTH-1:0];
                if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
            end
            S_FIX: begin
                done_d = 1'b1;
                if (divz_q) begin
                    hi_d  = opa_q;
                    lo_d  = '1;
                    dbz_d = 1'b1;
                end else begin
                    lo_d = qneg_q ? -opa_q : opa_q;
                    hi_d = rneg_q ? -rem_q : rem_q;
                end
            end
            default: ;
        endcase
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule
